bcd_display_scanner: RTL

//  Consumes the packed BCD digits produced by a chain of cascaded mod-10 counters and drives a

---
 rtl/bcd_disp_pkg.sv | 16 +
 rtl/bcd_to_seg.sv | 18 +
 rtl/bcd_display_scanner.sv | 102 ++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD display scanner: segment patterns and index sizing.
package bcd_disp_pkg;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to 7-segment decode; non-BCD codes show a dash.
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (blank)
            seg = SEG_BLANK;
        else if (digit <= 4'd9)
            seg = SEG_DIGIT[digit];
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner with frame-coherent snapshot, leading-zero
// blanking, anti-ghost blank slot and non-BCD flag.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE      = 4,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done,
    output logic                    bcd_err
);

    localparam int IW = idx_w(NUM_DIGITS);
    localparam int PW = idx_w(PRESCALE);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]                 pre_cnt;
    logic [IW-1:0]                 idx;
    logic [NUM_DIGITS-1:0][3:0]    shadow;
    logic [NUM_DIGITS-1:0][3:0]    staging;
    logic                          pend;

    logic       slot_end, wrap;
    logic       higher_zero, blank_sel, any_err;
    logic [3:0] sel_digit;
    logic [6:0] seg_dec;

    assign slot_end  = (pre_cnt == PRE_LAST);
    assign wrap      = slot_end && (idx == IDX_LAST);
    assign sel_digit = shadow[idx];

    // A digit is a leading zero when it and every more significant digit are 0
    always_comb begin
        higher_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (k >= int'(idx) && shadow[k] != 4'd0)
                higher_zero = 1'b0;
        blank_sel = (BLANK_LEADING != 0) && (idx != '0) && higher_zero;
    end

    always_comb begin
        any_err = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (shadow[k] > 4'd9)
                any_err = 1'b1;
    end

    bcd_to_seg u_dec (
        .digit (sel_digit),
        .blank (blank_sel),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt    <= '0;
            idx        <= '0;
            shadow     <= '0;
            staging    <= '0;
            pend       <= 1'b0;
            seg_out    <= '0;
            dig_en     <= '0;
            frame_done <= 1'b0;
            bcd_err    <= 1'b0;
        end else begin
            pre_cnt <= slot_end ? '0 : pre_cnt + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

            // Shadow only moves at the frame boundary so a frame never tears
            if (wrap) begin
                if (load)
                    shadow <= digits_in;
                else if (pend)
                    shadow <= staging;
                pend <= 1'b0;
            end else if (load) begin
                staging <= digits_in;
                pend    <= 1'b1;
            end

            if (pre_cnt == '0) begin
                dig_en  <= '0;
                seg_out <= SEG_BLANK;
            end else begin
                dig_en  <= NUM_DIGITS'(1) << idx;
                seg_out <= seg_dec;
            end
            frame_done <= wrap;
            bcd_err    <= any_err;
        end
    end

endmodule
